// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD 7-segment scanner: segment patterns, digit
// indices and the all-off anode pattern.
package bcd_disp_pkg;

  localparam int NUM_DIGITS = 3;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [1:0] digit_idx_t;
  localparam digit_idx_t DIG_ONES     = 2'd0;
  localparam digit_idx_t DIG_TENS     = 2'd1;
  localparam digit_idx_t DIG_HUNDREDS = 2'd2;

  localparam logic [NUM_DIGITS-1:0] AN_OFF = 3'b111;

  function automatic logic nib_bad(input logic [3:0] nib);
    return nib > 4'd9;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-decimal
// nibbles show a dash, blank forces all segments off.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) seg = SEG_BLANK;
    else begin
      case (nib)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/bcd_display_scan.sv
// 3-digit multiplexed common-anode display scanner: holds a BCD word, walks
// the digits at REFRESH_DIV cycles per slot with a blank guard per slot.
module bcd_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        bcd_valid,
  input  logic        blank_lz,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        bcd_err
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] DIV_MAX   = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] div_cnt_q, div_cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [11:0]   held_q, held_d;
  logic          err_q, err_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic          wrap, guard, lz_blank, off;
  logic [3:0]    nib;

  assign wrap = (div_cnt_q == DIV_MAX);

  always_comb begin
    div_cnt_d = wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = idx_q;
    if (wrap) idx_d = (idx_q == DIG_HUNDREDS) ? DIG_ONES : idx_q + 2'd1;
    held_d    = bcd_valid ? bcd : held_q;
    err_d     = bcd_valid ? (nib_bad(bcd[3:0]) | nib_bad(bcd[7:4]) | nib_bad(bcd[11:8]))
                          : err_q;
  end

  // A nibble > 9 is non-zero, so only a literal 0 qualifies for blanking.
  always_comb begin
    case (idx_q)
      DIG_TENS:     nib = held_q[7:4];
      DIG_HUNDREDS: nib = held_q[11:8];
      default:      nib = held_q[3:0];
    endcase
    guard    = (div_cnt_q < BLANK_LIM);
    lz_blank = blank_lz &&
               (((idx_q == DIG_HUNDREDS) && (held_q[11:8] == 4'd0)) ||
                ((idx_q == DIG_TENS) && (held_q[11:8] == 4'd0) && (held_q[7:4] == 4'd0)));
    off      = guard | lz_blank;
    an_d     = off ? AN_OFF : ~(3'b001 << idx_q);
  end

  bcd_to_seg7 u_dec (
    .nib   (nib),
    .blank (off),
    .seg   (seg_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      idx_q     <= DIG_ONES;
      held_q    <= 12'h000;
      err_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      an_q      <= AN_OFF;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      held_q    <= held_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign bcd_err = err_q;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a cycle-count reference model and
// literal spot checks at hand-computed slot positions.
module tb_bcd_display_scan;

  localparam int R = 4;
  localparam int B = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        blank_lz;
  logic [6:0]  seg;
  logic [2:0]  an;
  logic        bcd_err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  bcd_display_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd       (bcd),
    .bcd_valid (bcd_valid),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .an        (an),
    .bcd_err   (bcd_err)
  );

  always #5 clk = ~clk;

  // Reference model: slot position derived from cycles since reset.
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  int          m_c;
  int          m_d, m_i;
  logic [11:0] m_held;
  logic        m_err;
  logic [3:0]  m_nib, m_h, m_t;
  logic        m_blank;
  logic [6:0]  exp_seg;
  logic [2:0]  exp_an;
  logic        armed = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_c = 0; m_held = 12'h000; m_err = 1'b0;
      exp_seg = 7'h7F; exp_an = 3'b111;
    end else begin
      m_d = m_c % R;
      m_i = (m_c / R) % 3;
      m_nib = 4'((m_held >> (4 * m_i)) & 12'hF);
      m_h = m_held[11:8];
      m_t = m_held[7:4];
      m_blank = blank_lz && ((m_i == 2 && m_h == 0) || (m_i == 1 && m_h == 0 && m_t == 0));
      if (m_d < B || m_blank) begin
        exp_seg = 7'h7F; exp_an = 3'b111;
      end else begin
        exp_seg = seg_tab[m_nib];
        exp_an  = 3'(3'b111 ^ (1 << m_i));
      end
      if (bcd_valid) begin
        m_held = bcd;
        m_err  = (bcd[3:0] > 9) || (bcd[7:4] > 9) || (bcd[11:8] > 9);
      end
      m_c++;
    end
    armed = 1'b1;
  end

  always @(negedge clk) begin
    if (armed) begin
      check_cnt += 3;
      if (seg === exp_seg) pass_cnt++;
      else $display("FAIL model_seg t=%0t: seg=%h expected %h", $time, seg, exp_seg);
      if (an === exp_an) pass_cnt++;
      else $display("FAIL model_an t=%0t: an=%b expected %b", $time, an, exp_an);
      if (bcd_err === m_err) pass_cnt++;
      else $display("FAIL model_err t=%0t: bcd_err=%b expected %b", $time, bcd_err, m_err);
    end
  end

  task automatic go(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input logic [6:0] s, input logic [2:0] a);
    @(negedge clk);
    check_cnt++;
    if (seg === s && an === a) pass_cnt++;
    else $display("FAIL %s: seg=%h an=%b expected seg=%h an=%b", nm, seg, an, s, a);
  endtask

  task automatic lit_err(input string nm, input logic e);
    @(negedge clk);
    check_cnt++;
    if (bcd_err === e) pass_cnt++;
    else $display("FAIL %s: bcd_err=%b expected %b", nm, bcd_err, e);
  endtask

  initial begin
    rst = 1'b1; bcd = 12'h000; bcd_valid = 1'b0; blank_lz = 1'b0;
    go(1);  lit_err("rst_err", 1'b0);
    go(1);  lit("rst_out", 7'h7F, 3'b111);
    go(1);
    // release reset and load 255 on the first running edge
    rst = 1'b0; bcd = 12'h255; bcd_valid = 1'b1;
    go(1);  lit("first_guard", 7'h7F, 3'b111);
    bcd_valid = 1'b0;
    go(1);  lit("255_ones", 7'h12, 3'b110);
    go(4);  lit("255_tens", 7'h12, 3'b101);
    go(4);  lit("255_hund", 7'h24, 3'b011);
    go(12); lit("255_period", 7'h24, 3'b011);
    // 007 with leading-zero blanking
    bcd = 12'h007; bcd_valid = 1'b1; blank_lz = 1'b1;
    go(1);  bcd_valid = 1'b0;
    go(1);  lit("007_hund_lz", 7'h7F, 3'b111);
    go(2);  lit("007_ones", 7'h78, 3'b110);
    go(4);  lit("007_tens_lz", 7'h7F, 3'b111);
    blank_lz = 1'b0;
    go(1);  lit("007_tens_nolz", 7'h40, 3'b101);
    // non-decimal tens nibble
    bcd = 12'h1A3; bcd_valid = 1'b1;
    go(1);  lit_err("1A3_err", 1'b1);
    bcd_valid = 1'b0;
    go(10); lit("1A3_tens_dash", 7'h3F, 3'b101);
    bcd = 12'h100; bcd_valid = 1'b1; blank_lz = 1'b1;
    go(1);  lit_err("100_err_clr", 1'b0);
    bcd_valid = 1'b0;
    go(1);  lit("100_tens_zero", 7'h40, 3'b101);
    // load coincident with a slot wrap
    go(3);  bcd = 12'h999; bcd_valid = 1'b1;
    go(1);  bcd_valid = 1'b0;
    go(2);  lit("999_wrap_ones", 7'h10, 3'b110);
    // reset in the middle of the hundreds slot
    go(8);  rst = 1'b1;
    go(1);  lit("rst_mid", 7'h7F, 3'b111);
    rst = 1'b0;
    go(1);  lit("restart_guard", 7'h7F, 3'b111);
    go(1);  lit("restart_ones", 7'h40, 3'b110);
    blank_lz = 1'b0;
    go(24);
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Consumes the 12-bit, 3-digit BCD word produced by bin2bcd and drives a 3-digit, common-anode, multiplexed 7-segment display.
- Latches the BCD value on a load strobe and scans one digit at a time at a programmable refresh rate.
- Inserts an anti-ghosting blank guard at the start of each digit slot.
- Optionally blanks leading zeros and flags non-decimal nibbles.

Parameters:
- REFRESH_DIV, 1000: clock cycles per digit slot; must be >= 2.
- BLANK_CYCLES, 8: cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- bcd  input  12  BCD word; [3:0] ones, [7:4] tens, [11:8] hundreds.
- bcd_valid  input  1  load strobe; bcd is captured on any cycle where this is high.
- blank_lz  input  1  leading-zero blanking enable; sampled live every cycle, not latched.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- an  output  3  digit enables, active-low; an[0] ones, an[1] tens, an[2] hundreds.
- bcd_err  output  1  high while the held word contains a nibble > 9.

Behaviour:
- Reset (rst=1 at a clk edge):
  - held word = 12'h000, div_cnt = 0, digit index idx = 0.
  - seg = 7'h7F, an = 3'b111, bcd_err = 0.
  - Reset overrides bcd_valid in the same cycle.
  - Reset mid-scan: the scan restarts from idx 0 with div_cnt 0.
- Divider:
  - div_cnt counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and idx advances 0→1→2→0. idx never takes value 3.
- Load:
  - On bcd_valid=1, held <= bcd.
  - bcd_err <= 1 if any nibble of bcd > 9, else 0; it updates only on a load.
  - A load does not disturb div_cnt or idx.
  - Load coincident with a wrap: both take effect.
- Outputs are registered, with 1-cycle latency from the (div_cnt, idx, held) state.
  - Guard: if div_cnt < BLANK_CYCLES, then an = 3'b111 and seg = 7'h7F.
  - Otherwise an = ~(3'b001 << idx), and seg = decode of nibble idx of held.
- Leading-zero blanking (blank_lz=1):
  - Hundreds slot is blanked if hundreds == 0.
  - Tens slot is blanked if hundreds == 0 and tens == 0.
  - Ones is never blanked.
  - A blanked slot drives an = 3'b111 and seg = 7'h7F for the whole slot.
  - A nibble > 9 counts as non-zero for this rule.
- Decode, nibble value → seg:
  - 0 → 40, 1 → 79, 2 → 24, 3 → 30, 4 → 19
  - 5 → 12, 6 → 02, 7 → 78, 8 → 00, 9 → 10
  - 10..15 → 3F (dash, segment g only).
  - Blank → 7F.
- A new load is visible starting at the next non-guard cycle of whichever slot is current; no tearing within a cycle.

Decomposition:
- Shared package bcd_disp_pkg:
  - SEG_0..SEG_9, SEG_DASH, SEG_BLANK constants (7-bit).
  - digit_idx_t (2-bit) plus constants DIG_ONES=0, DIG_TENS=1, DIG_HUNDREDS=2.
  - AN_OFF = 3'b111.
- Sub-module bcd_to_seg7: purely combinational, 4-bit nibble plus blank flag → 7-bit active-low segments.
- The scanner holds all state: divider, index, held register, error flag, output registers.

Test Plan (REFRESH_DIV=4, BLANK_CYCLES=1 unless noted):
- rst held 3 cycles → seg=7F, an=111, bcd_err=0 every cycle.
- After rst drops → guard cycle, then ones slot driven, first index advance after 4 cycles.
- Load 12'h255, blank_lz=0 → per slot, after its guard cycle:
  - slot 0: an=110, seg=12.
  - slot 1: an=101, seg=12.
  - slot 2: an=011, seg=24.
  - Sequence repeats with period 12.
- Load 12'h007:
  - blank_lz=1 → tens and hundreds slots show an=111, seg=7F; ones shows an=110, seg=78.
  - Toggle blank_lz=0 mid-run → zeros show seg=40 from the next cycle.
- Load 12'h1A3 → bcd_err=1 one cycle after the load; tens slot shows seg=3F.
  - Then load 12'h100 with blank_lz=1 → bcd_err=0; tens shows seg=40 (not blanked, hundreds non-zero).
- Boundary: bcd_valid asserted on the wrap cycle with 12'h999 → next slot shows seg=10, idx still advances.
  - rst asserted mid-slot 2 → outputs off next cycle, held=000, scan restarts at slot 0.
